// File: rtl/add_res_pkg.sv
// Shared definitions for the add/sub result FIFO.
// Provides the default result width, the op tag encodings, and the stored
// entry layout {sel, bits}.
package add_res_pkg;

    // Result width produced by the 4-bit add/sub stage.
    localparam int DATA_W = 4;

    // Op tag values carried alongside every result.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One stored result: the op tag sits above the value bits.
    typedef struct packed {
        logic              sel;
        logic [DATA_W-1:0] bits;
    } res_entry_t;

endpackage

// File: rtl/add_res_fifo_mem.sv
// Register-array storage for the result FIFO.
// One synchronous write port and one asynchronous read port. The array is
// deliberately not reset; the top level masks the head while empty.
module add_res_fifo_mem #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head read is combinational so data is ready as soon as valid rises.
    assign rdata = mem[raddr];

endmodule

// File: rtl/add_res_fifo.sv
// Result FIFO behind the 4-bit add/sub unit.
// Buffers {sel, bits} results between the combinational arithmetic stage
// and a slow consumer, reports occupancy, and keeps a sticky drop flag for
// results offered while full.
// Optional feature: define ADD_RES_FIFO_SUM_EN to add io_sum, the running
// unsigned sum of the values currently held.
module add_res_fifo
    import add_res_pkg::*;
#(
    parameter int DATA_W = add_res_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    input  logic              io_in_sel,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_bits,
    output logic              io_out_sel,
    output logic [CNT_W-1:0]  io_count,
    output logic              io_drop,
`ifdef ADD_RES_FIFO_SUM_EN
    output logic [DATA_W+CNT_W-1:0] io_sum,
`endif
    input  logic              io_clr_drop
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               ENTRY_W  = DATA_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               drop_q;
    logic               push;
    logic               pop;
    logic               drop_set;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    // Handshake rules: a transfer happens on a side only in a cycle where
    // both its valid and ready are high. io_in_ready depends on the stored
    // count alone (never on io_in_valid), so a full FIFO refuses input even
    // when the head is popped that same cycle; an empty FIFO never bypasses,
    // so a pushed result shows at the head one cycle after the push.
    assign io_in_ready  = (count != FULL_CNT);
    assign io_out_valid = (count != '0);
    assign push         = io_in_valid & io_in_ready;
    assign pop          = io_out_valid & io_out_ready;
    assign drop_set     = io_in_valid & ~io_in_ready;

    assign wdata = {io_in_sel, io_in_bits};

    add_res_fifo_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Head outputs are forced to zero while empty since storage is not reset.
    always_comb begin
        io_out_bits = '0;
        io_out_sel  = OP_ADD;
        if (io_out_valid) begin
            io_out_bits = rdata[DATA_W-1:0];
            io_out_sel  = rdata[DATA_W];
        end
    end

    assign io_count = count;
    assign io_drop  = drop_q;

    // Pointer advance on each accepted transfer; wraps naturally at DEPTH-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: push alone adds one, pop alone removes one, both cancel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow record; a new drop in the clear cycle keeps it set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_q <= 1'b0;
        end else if (drop_set) begin
            drop_q <= 1'b1;
        end else if (io_clr_drop) begin
            drop_q <= 1'b0;
        end
    end

`ifdef ADD_RES_FIFO_SUM_EN
    localparam int SUM_W = DATA_W + CNT_W;

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_add;
    logic [SUM_W-1:0] sum_sub;

    // Per-cycle contributions; a pop always has a valid head behind it.
    always_comb begin
        sum_add = '0;
        sum_sub = '0;
        if (push) begin
            sum_add = SUM_W'(io_in_bits);
        end
        if (pop) begin
            sum_sub = SUM_W'(rdata[DATA_W-1:0]);
        end
    end

    // Running sum of held values, applying push and pop in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_q + sum_add - sum_sub;
        end
    end

    assign io_sum = sum_q;
`endif

endmodule
